regfile_32x64: RTL and testbench

- 32-entry × 64-bit integer register file for the CPU datapath, in the style of ARMv8 X0–X31.
- Two combinational read ports and one synchronous write port.
- Register 31 is hardwired to zero (XZR).
- Sits between decode (register addresses) and execute/writeback (operands, result data).

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_entry.sv | 19 +
 rtl/regfile_32x64.sv | 53 +++++
 tb/tb_regfile_32x64.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, zero-register index and data/address types for the register file.
package regfile_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one W-bit register with write enable and asynchronous active-low clear.
// Ports: clk, reset_n (async clear to 0), en (load d on rising clk), d (next value), q (stored value).
module regfile_entry #(
    parameter int W = regfile_pkg::DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] data_d, data_q;
    always_comb data_d = en ? d : data_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= data_d;
    end
    assign q = data_q;
endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: 32 x 64-bit register file, two combinational read ports, one synchronous write port.
// Register 31 has no storage and always reads zero; writes to it are dropped.
// Ports: clk, reset_n (async active-low clear of all registers),
//        ReadRegister1/ReadRegister2 -> ReadData1/ReadData2 (zero-latency reads),
//        WriteRegister/WriteData/RegWrite (write on rising clk).
// Optional: define REGFILE_BYPASS_EN to forward WriteData to a read port whose
//           address matches an enabled write before the clock edge.
module regfile_32x64 #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    import regfile_pkg::*;
    localparam int N_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(N_REGS-1);
    logic                  wr_ok;
    logic [N_REGS-2:0]     we;
    logic [DATA_WIDTH-1:0] regs [N_REGS];
    logic                  fwd1, fwd2;
    assign wr_ok = RegWrite && (WriteRegister != ZR);
    // one-hot decode; the top register has no enable line at all
    assign we = wr_ok ? (N_REGS-1)'(1) << WriteRegister : '0;
    genvar i;
    for (i = 0; i < N_REGS-1; i++) begin : gen_reg
        regfile_entry #(.W(DATA_WIDTH)) u_entry (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (we[i]),
            .d       (WriteData),
            .q       (regs[i])
        );
    end
    assign regs[N_REGS-1] = '0;
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes the zero register, so it keeps reading 0
    assign fwd1 = wr_ok && (ReadRegister1 == WriteRegister);
    assign fwd2 = wr_ok && (ReadRegister2 == WriteRegister);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    assign ReadData1 = fwd1 ? WriteData : regs[ReadRegister1];
    assign ReadData2 = fwd2 ? WriteData : regs[ReadRegister2];
endmodule

// File: tb/tb_regfile_32x64.sv
// tb_regfile_32x64: scoreboard bench for regfile_32x64 against a 32-entry reference model.
module tb_regfile_32x64;
    import regfile_pkg::*;
    logic      clk = 1'b0;
    logic      reset_n = 1'b0;
    reg_addr_t ReadRegister1 = '0, ReadRegister2 = '0, WriteRegister = '0;
    reg_data_t WriteData = '0;
    logic      RegWrite = 1'b0;
    reg_data_t ReadData1, ReadData2;

    regfile_32x64 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     tag;
        bit        port;
        reg_data_t exp;
    } exp_t;

    exp_t      sb[$];
    reg_data_t mdl [NUM_REGS];
    int        checks = 0;
    int        errors = 0;
    localparam reg_data_t PAT = 64'h0000010204080001;

    task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit port, input reg_data_t exp);
        exp_t e;
        e.tag = tag;
        e.port = port;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, e.port ? ReadData2 : ReadData1, e.exp);
        end
    endtask

    task automatic rd2(input string tag, input int a1, input int a2);
        ReadRegister1 = reg_addr_t'(a1);
        ReadRegister2 = reg_addr_t'(a2);
        push($sformatf("%s_p1_r%0d", tag, a1), 1'b0, mdl[a1]);
        push($sformatf("%s_p2_r%0d", tag, a2), 1'b1, mdl[a2]);
        drain();
    endtask

    task automatic wr(input int a, input reg_data_t d);
        @(negedge clk);
        WriteRegister = reg_addr_t'(a);
        WriteData = d;
        RegWrite = 1'b1;
        @(negedge clk);
        RegWrite = 1'b0;
        if (a != 31) mdl[a] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        #12;
        rd2("reset_low", 0, 30);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) rd2("after_reset", i, NUM_REGS-1-i);
        wr(31, 64'hA0);
        rd2("zero_reg", 31, 31);
        for (int i = 0; i < 31; i++) wr(i, PAT * i);
        for (int i = 0; i < NUM_REGS; i++) rd2("fill", i, (i + 13) % NUM_REGS);
        ReadRegister1 = 5'd3;
        #1;
        chk("reg3_const", ReadData1, 64'h000003060C180003);
        @(negedge clk);
        RegWrite = 1'b0;
        WriteRegister = 5'd5;
        WriteData = '1;
        repeat (3) @(negedge clk);
        rd2("wr_disable", 5, 5);
        wr(8, 64'h8888_0000_0000_0008);
        @(negedge clk);
        rd2("dual_rd", 7, 8);
        WriteRegister = 5'd7;
        WriteData = 64'h1234;
        RegWrite = 1'b1;
`ifdef REGFILE_BYPASS_EN
        push("rdw_before", 1'b0, 64'h1234);
`else
        push("rdw_before", 1'b0, mdl[7]);
`endif
        push("rdw_other", 1'b1, mdl[8]);
        drain();
        @(posedge clk);
        mdl[7] = 64'h1234;
        push("rdw_after", 1'b0, 64'h1234);
        drain();
        @(negedge clk);
        RegWrite = 1'b0;
        wr(10, 64'hDEAD_BEEF);
        rd2("pre_async", 10, 7);
        @(negedge clk);
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd7;
        WriteRegister = 5'd10;
        WriteData = 64'h5555;
        RegWrite = 1'b1;
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        push("async_r10", 1'b0, '0);
        push("async_r7", 1'b1, '0);
        drain();
        @(posedge clk);
        push("reset_wins", 1'b0, '0);
        drain();
        @(negedge clk);
        RegWrite = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i += 3) rd2("post_async", i, i + 1 < NUM_REGS ? i + 1 : 0);
        wr(10, 64'hCAFE);
        rd2("rewrite", 10, 11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
